stepdown_deadtime_seq: RTL and testbench
========================================

Name: stepdown_deadtime_seq

Overview:
- Consumes the 2 ns both-edge delayed PWM produced by the fixed delay cell in the stepdown loop control (XCONTROL).
- Synchronises the delayed PWM into the controller clock domain.
- Sequences the high-side and low-side gate enables through programmable dead times, enforcing minimum on and off times.
- Gates output on enable and fault; counts delivered high-side pulses for loop telemetry.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on pwm_dly (legal range 2-3).
- CNT_W, 4, width of the dead-time and min-time counters.
- DT_LH, 3, cycles with both gates off between ls_on falling and hs_on rising (legal range 1 to 2^CNT_W-1).
- DT_HL, 3, cycles with both gates off between hs_on falling and ls_on rising (same range).
- MIN_ON, 2, minimum cycles hs_on stays high once asserted (legal range 1 to 2^CNT_W-1).
- MIN_OFF, 2, minimum cycles ls_on stays high once asserted (same range).

Ports:
- CELCLK  in  1  controller clock; all state changes on the rising edge.
- CELRST  in  1  asynchronous active-high reset.
- CELV  in  1  supply tie; no functional effect.
- CELG  in  1  ground tie; no functional effect.
- CELSUB  in  1  substrate tie; no functional effect.
- pwm_dly  in  1  delayed PWM from the delay cell; asynchronous to CELCLK.
- en  in  1  converter enable.
- fault  in  1  fault request (OCP/UVLO), level-sensitive.
- hs_on  out  1  high-side gate enable, registered.
- ls_on  out  1  low-side gate enable, registered.
- fault_lat  out  1  high while in FAULT.
- busy  out  1  high in any state other than IDLE and FAULT.
- pulse_cnt  out  8  count of entries into HS_ON; wraps 255 -> 0.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; hs_on = 0, ls_on = 0, fault_lat = 0, busy = 0, pulse_cnt = 0.
  - Synchroniser flops clear to 0.
  - Reset mid-pulse drops both gates immediately, without waiting for a clock.
- Synchroniser: pwm_s is the last of SYNC_STAGES flops. A pwm_dly change set up before edge k appears on pwm_s after edge k+SYNC_STAGES-1.
- States: IDLE, DT_LH, HS_ON, DT_HL, LS_ON, FAULT. Per-state outputs:
  - IDLE, DT_LH, DT_HL, FAULT: hs_on = 0, ls_on = 0.
  - HS_ON: hs_on = 1, ls_on = 0.
  - LS_ON: hs_on = 0, ls_on = 1.
  - Outputs are decoded from registered state (flopped), so they change on the same edge as the state.
- Transition priority each cycle:
  - 1) fault=1 -> FAULT.
  - 2) en=0 -> IDLE.
  - 3) The normal transitions below.
- Normal transitions:
  - IDLE: if en=1 and pwm_s=1 -> DT_LH; if en=1 and pwm_s=0 -> DT_HL.
  - DT_LH: counter loaded with DT_LH on entry and decremented each cycle. At count 1 -> HS_ON, so both gates are off for exactly DT_LH cycles. If pwm_s=0 during DT_LH -> DT_HL with counter reloaded to DT_HL (aborted pulse; pulse_cnt unchanged).
  - HS_ON: counter counts cycles in state. Exit to DT_HL on the first cycle with count >= MIN_ON and pwm_s=0. pwm_s falling earlier is ignored until MIN_ON elapses; only the current pwm_s level is evaluated, with no latching.
  - DT_HL: mirror of DT_LH, using DT_HL. At count 1 -> LS_ON; pwm_s=1 during DT_HL -> DT_LH reloaded.
  - LS_ON: exit to DT_LH on the first cycle with count >= MIN_OFF and pwm_s=1.
  - FAULT: exit to IDLE only when fault=0 and en=0 on the same cycle (en must be cycled to restart).
- pulse_cnt increments on the edge that enters HS_ON, and on no other edge.
- Invariants:
  - hs_on and ls_on are never both 1.
  - Every hs_on/ls_on handover passes through a dead-time state of at least the parameter length.
- Latency: pwm_dly rising (set up before edge k, with the FSM in LS_ON past MIN_OFF) causes:
  - ls_on = 0 at edge k+SYNC_STAGES.
  - hs_on = 1 at edge k+SYNC_STAGES+DT_LH.
  - Falling edges are symmetric, using DT_HL.
- Simultaneous events: fault and en=0 together -> FAULT. A fault during a dead-time or on-state drops gates the next edge and freezes pulse_cnt.
- Parameters outside their legal ranges are a static elaboration error.

Test Plan:
- Reset, then en=1 with pwm_dly=0 -> DT_HL for 3 cycles with both gates 0, then ls_on=1; pulse_cnt=0.
- From LS_ON (MIN_OFF met), pwm_dly rises before edge 10 -> ls_on=0 at edge 12, hs_on=1 at edge 15, pulse_cnt=1; pwm_dly falls before edge 30 -> hs_on=0 at edge 32, ls_on=1 at edge 35.
- 1-cycle-wide pwm_s high pulse while in LS_ON -> DT_LH then abort to DT_HL; hs_on never asserts; pulse_cnt unchanged.
- pwm_s falls 1 cycle after HS_ON entry (MIN_ON=2) -> hs_on held for exactly 2 cycles, then DT_HL.
- fault=1 while in HS_ON -> hs_on=0 and fault_lat=1 next edge. Clearing fault with en=1 keeps FAULT; then en=0 -> IDLE; then en=1 -> restarts.
- 256 full PWM periods -> pulse_cnt wraps to 0. CELRST asserted mid-HS_ON -> hs_on=0 with no clock edge.

Source files
------------

// File: rtl/stepdown_deadtime_seq.sv
// stepdown_deadtime_seq: synchronises delayed PWM and sequences hs/ls gate enables
// through programmable dead times with min on/off enforcement and pulse telemetry.
module stepdown_deadtime_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int DT_LH       = 3,
  parameter int DT_HL       = 3,
  parameter int MIN_ON      = 2,
  parameter int MIN_OFF     = 2
) (
  input  logic       CELCLK,
  input  logic       CELRST,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       CELSUB,
  input  logic       pwm_dly,
  input  logic       en,
  input  logic       fault,
  output logic       hs_on,
  output logic       ls_on,
  output logic       fault_lat,
  output logic       busy,
  output logic [7:0] pulse_cnt
);
  localparam int CMAX = (1 << CNT_W) - 1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
      DT_LH < 1 || DT_LH > CMAX || DT_HL < 1 || DT_HL > CMAX ||
      MIN_ON < 1 || MIN_ON > CMAX || MIN_OFF < 1 || MIN_OFF > CMAX) begin : g_bad_param
    $error("stepdown_deadtime_seq: parameter outside legal range");
  end

  typedef enum logic [2:0] {S_IDLE, S_DT_LH, S_HS_ON, S_DT_HL, S_LS_ON, S_FAULT} state_t;

  state_t                 state, nxt;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   pwm_s;
  logic                   unused_ties;

  assign unused_ties = ^{CELV, CELG, CELSUB};
  assign pwm_s = sync[SYNC_STAGES-1];

  always_comb begin
    nxt = state;
    if (fault) nxt = S_FAULT;
    else if (!en) nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  nxt = pwm_s ? S_DT_LH : S_DT_HL;
        S_DT_LH: nxt = !pwm_s ? S_DT_HL : cnt == CNT_W'(1) ? S_HS_ON : S_DT_LH;
        S_HS_ON: nxt = (cnt >= CNT_W'(MIN_ON) && !pwm_s) ? S_DT_HL : S_HS_ON;
        S_DT_HL: nxt = pwm_s ? S_DT_LH : cnt == CNT_W'(1) ? S_LS_ON : S_DT_HL;
        S_LS_ON: nxt = (cnt >= CNT_W'(MIN_OFF) && pwm_s) ? S_DT_LH : S_LS_ON;
        S_FAULT: nxt = S_FAULT;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // dead-time states count down from their load value; on-states count up and saturate at their minimum
  always_comb begin
    cnt_n = (nxt != state) ? (nxt == S_DT_LH ? CNT_W'(DT_LH) : nxt == S_DT_HL ? CNT_W'(DT_HL) : CNT_W'(1))
          : (state == S_DT_LH || state == S_DT_HL) ? cnt - CNT_W'(1)
          : state == S_HS_ON ? cnt + CNT_W'(cnt < CNT_W'(MIN_ON))
          : state == S_LS_ON ? cnt + CNT_W'(cnt < CNT_W'(MIN_OFF))
          : cnt;
  end

  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      sync      <= '0;
      state     <= S_IDLE;
      cnt       <= '0;
      hs_on     <= 1'b0;
      ls_on     <= 1'b0;
      fault_lat <= 1'b0;
      busy      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], pwm_dly};
      state     <= nxt;
      cnt       <= cnt_n;
      hs_on     <= nxt == S_HS_ON;
      ls_on     <= nxt == S_LS_ON;
      fault_lat <= nxt == S_FAULT;
      busy      <= nxt != S_IDLE && nxt != S_FAULT;
      pulse_cnt <= pulse_cnt + 8'(nxt == S_HS_ON && state != S_HS_ON);
    end
  end
endmodule

// File: tb/tb_stepdown_deadtime_seq.sv
// tb_stepdown_deadtime_seq: directed stimulus with a cycle-stamped expectation queue
// compared on the falling clock edge; edge n is the n-th rising edge of the run.
module tb_stepdown_deadtime_seq;
  logic       CELCLK = 1'b0;
  logic       CELRST = 1'b1;
  logic       pwm_dly = 1'b0;
  logic       en = 1'b0;
  logic       fault = 1'b0;
  logic       hs_on, ls_on, fault_lat, busy;
  logic [7:0] pulse_cnt;

  int asserts = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct packed {
    int          at;
    int          id;
    logic [11:0] v;
  } exp_t;

  exp_t q[$];

  stepdown_deadtime_seq dut (
    .CELCLK(CELCLK), .CELRST(CELRST), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0),
    .pwm_dly(pwm_dly), .en(en), .fault(fault),
    .hs_on(hs_on), .ls_on(ls_on), .fault_lat(fault_lat), .busy(busy), .pulse_cnt(pulse_cnt)
  );

  always #5 CELCLK = ~CELCLK;
  always @(posedge CELCLK) cyc <= cyc + 1;

  function automatic void push(int at, int id, logic hs, logic ls, logic fl, logic bz, int pc);
    exp_t e;
    e.at = at;
    e.id = id;
    e.v = {hs, ls, fl, bz, 8'(pc)};
    q.push_back(e);
  endfunction

  task automatic go(int n);
    do @(negedge CELCLK); while (cyc < n);
  endtask

  always @(negedge CELCLK) begin
    exp_t e;
    asserts++;
    assert (!(hs_on === 1'b1 && ls_on === 1'b1)) else begin
      fails++;
      $error("FAIL overlap cycle %0d: hs_on=%b ls_on=%b, required not both 1", cyc, hs_on, ls_on);
    end
    while (q.size() != 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      asserts++;
      assert ({hs_on, ls_on, fault_lat, busy, pulse_cnt} === e.v) else begin
        fails++;
        $error("FAIL chk%0d cycle %0d: observed hs/ls/flt/busy/cnt=%b%b%b%b/%0d expected %b%b%b%b/%0d",
               e.id, cyc, hs_on, ls_on, fault_lat, busy, pulse_cnt,
               e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
      end
    end
  end

  initial begin
    push(2, 1, 0, 0, 0, 0, 0);
    go(2);
    CELRST = 1'b0;
    en = 1'b1;
    push(3, 2, 0, 0, 0, 1, 0);
    push(5, 3, 0, 0, 0, 1, 0);
    push(6, 4, 0, 1, 0, 1, 0);
    go(9);
    pwm_dly = 1'b1;
    push(11, 5, 0, 1, 0, 1, 0);
    push(12, 6, 0, 0, 0, 1, 0);
    push(14, 7, 0, 0, 0, 1, 0);
    push(15, 8, 1, 0, 0, 1, 1);
    go(29);
    pwm_dly = 1'b0;
    push(31, 9, 1, 0, 0, 1, 1);
    push(32, 10, 0, 0, 0, 1, 1);
    push(34, 11, 0, 0, 0, 1, 1);
    push(35, 12, 0, 1, 0, 1, 1);
    go(40);
    pwm_dly = 1'b1;
    push(43, 13, 0, 0, 0, 1, 1);
    push(44, 14, 0, 0, 0, 1, 1);
    push(45, 15, 0, 0, 0, 1, 1);
    push(46, 16, 0, 0, 0, 1, 1);
    push(47, 17, 0, 1, 0, 1, 1);
    go(41);
    pwm_dly = 1'b0;
    go(50);
    pwm_dly = 1'b1;
    push(55, 18, 0, 0, 0, 1, 1);
    push(56, 19, 1, 0, 0, 1, 2);
    push(57, 20, 1, 0, 0, 1, 2);
    push(58, 21, 0, 0, 0, 1, 2);
    push(61, 22, 0, 1, 0, 1, 2);
    go(55);
    pwm_dly = 1'b0;
    go(65);
    pwm_dly = 1'b1;
    push(71, 23, 1, 0, 0, 1, 3);
    go(72);
    fault = 1'b1;
    push(73, 24, 0, 0, 1, 0, 3);
    go(75);
    fault = 1'b0;
    push(77, 25, 0, 0, 1, 0, 3);
    go(78);
    en = 1'b0;
    push(79, 26, 0, 0, 0, 0, 3);
    go(80);
    en = 1'b1;
    push(81, 27, 0, 0, 0, 1, 3);
    push(84, 28, 1, 0, 0, 1, 4);
    go(86);
    fault = 1'b1;
    en = 1'b0;
    push(87, 29, 0, 0, 1, 0, 4);
    go(88);
    fault = 1'b0;
    pwm_dly = 1'b0;
    push(89, 30, 0, 0, 0, 0, 4);
    go(90);
    en = 1'b1;
    push(94, 31, 0, 1, 0, 1, 4);
    for (int i = 0; i < 252; i++) begin
      int t;
      t = 100 + 20 * i;
      go(t);
      pwm_dly = 1'b1;
      push(t + 6, 100 + i, 1, 0, 0, 1, (5 + i) & 255);
      go(t + 10);
      pwm_dly = 1'b0;
    end
    go(5140);
    pwm_dly = 1'b1;
    push(5146, 40, 1, 0, 0, 1, 1);
    go(5147);
    asserts++;
    assert (hs_on === 1'b1) else begin
      fails++;
      $error("FAIL pre_reset_hs: observed %b expected 1", hs_on);
    end
    #2 CELRST = 1'b1;
    #1;
    asserts++;
    assert ({hs_on, ls_on, fault_lat, busy, pulse_cnt} === 12'h000) else begin
      fails++;
      $error("FAIL async_reset: observed hs/ls/flt/busy/cnt=%b%b%b%b/%0d expected 0000/0",
             hs_on, ls_on, fault_lat, busy, pulse_cnt);
    end
    go(5149);
    CELRST = 1'b0;
    asserts++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL queue_drain: observed %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
